// File: rtl/starter_pkg.sv
// rtl/starter_pkg.sv - shared constants and beat type for the starter stream family
// Contents:
//   STARTER_DATA_W  default beat width
//   STARTER_DEPTH   default buffer depth
//   starter_beat_t  {data, valid} beat record for agents and scoreboards
package starter_pkg;

   localparam int STARTER_DATA_W = 8;
   localparam int STARTER_DEPTH  = 16;

   typedef struct packed {
      logic [STARTER_DATA_W-1:0] data;
      logic                      valid;
   } starter_beat_t;

endpackage

// File: rtl/starter_fifo_mem.sv
// rtl/starter_fifo_mem.sv - DATA_W x DEPTH register array, one write port, one async read port
// Ports:
//   clk    clock, write on rising edge
//   we     write enable
//   waddr  write address
//   wdata  write data
//   raddr  read address
//   rdata  combinational read data at raddr
module starter_fifo_mem
   import starter_pkg::*;
#(
   parameter int DATA_W = STARTER_DATA_W,
   parameter int DEPTH  = STARTER_DEPTH
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [DATA_W-1:0]        wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [DATA_W-1:0]        rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   // Contents are deliberately not reset; validity is tracked by the level counter.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/starter_stream_buffer.sv
// rtl/starter_stream_buffer.sv - push-only stream to valid/ready FIFO with level, afull and drop accounting
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   in_data, in_valid   push-only input stream, no backpressure
//   out_data, out_valid first-word fall-through head of FIFO
//   out_ready           consumer accepts the head this cycle
//   level               current occupancy (0..DEPTH)
//   afull               level >= AFULL_TH
//   overflow            sticky, set when a beat is dropped
//   drop_cnt            saturating count of dropped beats
//   clr_ovf             synchronous clear of overflow and drop_cnt
module starter_stream_buffer
   import starter_pkg::*;
#(
   parameter int DATA_W   = STARTER_DATA_W,
   parameter int DEPTH    = STARTER_DEPTH,
   parameter int AFULL_TH = 12,
   parameter int DROP_W   = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [DATA_W-1:0]      in_data,
   input  logic                   in_valid,
   output logic [DATA_W-1:0]      out_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [$clog2(DEPTH):0] level,
   output logic                   afull,
   output logic                   overflow,
   output logic [DROP_W-1:0]      drop_cnt,
   input  logic                   clr_ovf
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam logic [LVL_W-1:0]  LVL_FULL  = LVL_W'(DEPTH);
   localparam logic [LVL_W-1:0]  LVL_AFULL = LVL_W'(AFULL_TH);
   localparam logic [DROP_W-1:0] DROP_MAX  = '1;

   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [LVL_W-1:0] level_nxt;
   logic             full;
   logic             pop;
   logic             push_ok;
   logic             drop;

   assign out_valid = (level != '0);
   assign full      = (level == LVL_FULL);
   assign pop       = out_valid & out_ready;
   // A full buffer still accepts a beat when the head leaves in the same cycle.
   assign push_ok   = in_valid & (~full | pop);
   assign drop      = in_valid & full & ~pop;

   always_comb begin
      level_nxt = level;
      case ({push_ok, pop})
         2'b10:   level_nxt = level + LVL_W'(1);
         2'b01:   level_nxt = level - LVL_W'(1);
         default: level_nxt = level;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         afull  <= 1'b0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         level <= level_nxt;
         // Registered from the next level so afull lines up with level.
         afull <= (level_nxt >= LVL_AFULL);
      end
   end

   // A drop in the same cycle as clr_ovf wins: the counter restarts at one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow <= 1'b0;
         drop_cnt <= '0;
      end else if (drop) begin
         overflow <= 1'b1;
         if (clr_ovf) begin
            drop_cnt <= DROP_W'(1);
         end else if (drop_cnt != DROP_MAX) begin
            drop_cnt <= drop_cnt + DROP_W'(1);
         end
      end else if (clr_ovf) begin
         overflow <= 1'b0;
         drop_cnt <= '0;
      end
   end

   starter_fifo_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_mem (
      .clk   (clk),
      .we    (push_ok),
      .waddr (wr_ptr),
      .wdata (in_data),
      .raddr (rd_ptr),
      .rdata (out_data)
   );

   a_level_bound : assert property (@(posedge clk) disable iff (rst) level <= LVL_FULL);
   a_no_empty_pop : assert property (@(posedge clk) disable iff (rst) pop |-> (level != '0));
   a_stall_stable : assert property (@(posedge clk) disable iff (rst)
      (out_valid & ~out_ready) |=> (out_valid & $stable(out_data)));

endmodule

// File: tb/tb_starter_stream_buffer.sv
// tb/tb_starter_stream_buffer.sv - directed self-checking bench for starter_stream_buffer
module tb_starter_stream_buffer;

   logic        clk;
   logic        rst;

   logic [7:0]  in_data;
   logic        in_valid;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready;
   logic [4:0]  level;
   logic        afull;
   logic        overflow;
   logic [15:0] drop_cnt;
   logic        clr_ovf;

   logic [7:0]  b_in_data;
   logic        b_in_valid;
   logic [7:0]  b_out_data;
   logic        b_out_valid;
   logic        b_out_ready;
   logic [2:0]  b_level;
   logic        b_afull;
   logic        b_overflow;
   logic [1:0]  b_drop_cnt;
   logic        b_clr_ovf;

   int n_tests = 0;
   int n_fail  = 0;

   starter_stream_buffer #(
      .DATA_W(8), .DEPTH(16), .AFULL_TH(12), .DROP_W(16)
   ) dut (
      .clk(clk), .rst(rst),
      .in_data(in_data), .in_valid(in_valid),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .level(level), .afull(afull), .overflow(overflow),
      .drop_cnt(drop_cnt), .clr_ovf(clr_ovf)
   );

   starter_stream_buffer #(
      .DATA_W(8), .DEPTH(4), .AFULL_TH(3), .DROP_W(2)
   ) dut_small (
      .clk(clk), .rst(rst),
      .in_data(b_in_data), .in_valid(b_in_valid),
      .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
      .level(b_level), .afull(b_afull), .overflow(b_overflow),
      .drop_cnt(b_drop_cnt), .clr_ovf(b_clr_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      in_data = '0; in_valid = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0;
      b_in_data = '0; b_in_valid = 1'b0; b_out_ready = 1'b0; b_clr_ovf = 1'b0;
      cyc(); cyc();
      rst = 1'b0;
      cyc();

      check("rst_level", 32'(level), 0);
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_afull", 32'(afull), 0);
      check("rst_overflow", 32'(overflow), 0);
      check("rst_drop_cnt", 32'(drop_cnt), 0);

      // out_ready on an empty buffer does nothing
      out_ready = 1'b1;
      cyc();
      check("empty_ready_level", 32'(level), 0);
      out_ready = 1'b0;

      // fill 0x01..0x10
      for (int i = 1; i <= 16; i++) begin
         in_data = 8'(i); in_valid = 1'b1;
         cyc();
         check("fill_level", 32'(level), 32'(i));
         check("fill_afull", 32'(afull), (i >= 12) ? 1 : 0);
      end
      check("fill_overflow", 32'(overflow), 0);

      // three drops into a full buffer
      for (int i = 0; i < 3; i++) begin
         in_data = 8'(8'hE0 + i); in_valid = 1'b1;
         cyc();
         check("ovf_level", 32'(level), 16);
      end
      in_valid = 1'b0;
      check("ovf_overflow", 32'(overflow), 1);
      check("ovf_drop_cnt", 32'(drop_cnt), 3);

      // drain original beats only
      out_ready = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         check("drain_valid", 32'(out_valid), 1);
         check("drain_data", 32'(out_data), 32'(i));
         cyc();
      end
      out_ready = 1'b0;
      check("drain_level", 32'(level), 0);
      check("drain_out_valid", 32'(out_valid), 0);
      check("drain_overflow_sticky", 32'(overflow), 1);

      clr_ovf = 1'b1;
      cyc();
      clr_ovf = 1'b0;
      check("clr_overflow", 32'(overflow), 0);
      check("clr_drop_cnt", 32'(drop_cnt), 0);

      // full buffer: push and pop in the same cycle
      for (int i = 0; i < 16; i++) begin
         in_data = 8'(8'h30 + i); in_valid = 1'b1;
         cyc();
      end
      in_data = 8'hAA; in_valid = 1'b1; out_ready = 1'b1;
      cyc();
      in_valid = 1'b0; out_ready = 1'b0;
      check("pp_level", 32'(level), 16);
      check("pp_drop_cnt", 32'(drop_cnt), 0);
      check("pp_overflow", 32'(overflow), 0);
      out_ready = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         check("pp_data", 32'(out_data), (i == 16) ? 32'hAA : 32'(8'h30 + i));
         cyc();
      end
      out_ready = 1'b0;
      check("pp_level_end", 32'(level), 0);

      // stall stability
      in_data = 8'h5C; in_valid = 1'b1;
      cyc();
      in_valid = 1'b0; in_data = 8'h00;
      for (int i = 0; i < 5; i++) begin
         check("stall_valid", 32'(out_valid), 1);
         check("stall_data", 32'(out_data), 32'h5C);
         cyc();
      end
      out_ready = 1'b1;
      cyc();
      out_ready = 1'b0;
      check("stall_level", 32'(level), 0);

      // async reset mid-cycle with level 7
      for (int i = 0; i < 7; i++) begin
         in_data = 8'(8'h70 + i); in_valid = 1'b1;
         cyc();
      end
      in_valid = 1'b0;
      check("ar_level_pre", 32'(level), 7);
      #3;
      rst = 1'b1;
      #1;
      check("ar_level", 32'(level), 0);
      check("ar_out_valid", 32'(out_valid), 0);
      @(negedge clk);
      rst = 1'b0;
      cyc();
      in_data = 8'h99; in_valid = 1'b1;
      cyc();
      in_valid = 1'b0;
      check("ar_first_level", 32'(level), 1);
      check("ar_first_valid", 32'(out_valid), 1);
      check("ar_first_data", 32'(out_data), 32'h99);

      // small instance: afull, saturation and clear race
      for (int i = 1; i <= 4; i++) begin
         b_in_data = 8'(i); b_in_valid = 1'b1;
         cyc();
         check("sm_afull", 32'(b_afull), (i >= 3) ? 1 : 0);
      end
      for (int i = 0; i < 5; i++) begin
         cyc();
      end
      b_in_valid = 1'b0;
      check("sm_sat_drop_cnt", 32'(b_drop_cnt), 3);
      check("sm_sat_overflow", 32'(b_overflow), 1);
      check("sm_sat_level", 32'(b_level), 4);

      b_in_valid = 1'b1; b_clr_ovf = 1'b1;
      cyc();
      b_in_valid = 1'b0; b_clr_ovf = 1'b0;
      check("sm_race_overflow", 32'(b_overflow), 1);
      check("sm_race_drop_cnt", 32'(b_drop_cnt), 1);

      b_clr_ovf = 1'b1;
      cyc();
      b_clr_ovf = 1'b0;
      check("sm_clr_overflow", 32'(b_overflow), 0);
      check("sm_clr_drop_cnt", 32'(b_drop_cnt), 0);

      b_out_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         check("sm_drain_data", 32'(b_out_data), 32'(i));
         cyc();
      end
      b_out_ready = 1'b0;
      check("sm_drain_level", 32'(b_level), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/starter_stream_buffer.md
Name: starter_stream_buffer

Overview:
- Parametrised successor to the 8-bit data/valid starter stream.
- Accepts a push-only data/valid stream with no backpressure, buffers it in a DEPTH-entry FIFO, and presents it on a valid/ready output.
- Reports fill level, almost-full, sticky overflow and a saturating drop count, so agents and scoreboards can attribute lost beats.
- Sits between a starter-style stimulus/DUT port and any consumer that needs flow control.

Parameters:
- DATA_W, 8, width of data in bits (≥1).
- DEPTH, 16, FIFO entries; power of two, ≥2.
- AFULL_TH, 12, level at or above which afull asserts (1..DEPTH).
- DROP_W, 16, width of the drop counter.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  asynchronous active-high reset.
- in_data  in  DATA_W  input beat.
- in_valid  in  1  input beat present this cycle; no ready returned.
- out_data  out  DATA_W  head-of-FIFO data.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer accepts head this cycle.
- level  out  $clog2(DEPTH)+1  current occupancy.
- afull  out  1  level ≥ AFULL_TH.
- overflow  out  1  sticky: a beat was dropped.
- drop_cnt  out  DROP_W  dropped beats, saturating.
- clr_ovf  in  1  synchronous clear of overflow and drop_cnt.

Behaviour:
- Interface decision: one clock (clk). Reset (rst) is asynchronous and active-high.
- Reset values: level=0, out_valid=0, afull=0, overflow=0, drop_cnt=0, read/write pointers=0. out_data is don't-care while out_valid=0; the bench must not check it.
- Storage is a register array.
  - wr_ptr and rd_ptr are $clog2(DEPTH) bits wide and wrap naturally modulo DEPTH.
  - level is a separate counter.
- pop = out_valid & out_ready.
- push_ok = in_valid & (level<DEPTH | pop), so a full FIFO accepts a push in the same cycle as a pop.
- Per cycle:
  - push_ok writes in_data at wr_ptr, then wr_ptr+1.
  - pop advances rd_ptr.
  - level += push_ok − pop. Simultaneous push and pop leave level unchanged.
- First-word fall-through.
  - out_valid = (level≠0); out_data = mem[rd_ptr], combinational from the registered array.
  - Latency: a beat pushed in cycle N is visible on out_data/out_valid in cycle N+1.
  - A push into an empty FIFO cannot be popped in the same cycle (no bypass).
- Output handshake:
  - out_data and out_valid stay stable while out_valid=1 & out_ready=0.
  - out_ready while out_valid=0 has no effect.
- Drop condition: in_valid & level==DEPTH & ~pop.
  - The beat is discarded and pointers are unchanged.
  - overflow is set to 1 next cycle.
  - drop_cnt increments and saturates at 2^DROP_W−1; no wrap.
- clr_ovf: next cycle overflow=0 and drop_cnt=0. If a drop occurs in the same cycle, the drop wins: overflow=1 and drop_cnt=1.
- afull is registered-equivalent, derived from the updated level, so it is valid in the same cycle as level.
- Reset mid-operation: all contents are discarded immediately (asynchronous). out_valid deasserts without waiting for a clock edge.
- Empty: a pop is impossible, so level never underflows. Full: level never exceeds DEPTH.
- Assertions to include:
  - level ≤ DEPTH.
  - No pop when level==0.
  - out_data stable under stall.

Decomposition:
- Shared package starter_pkg holds:
  - Default constants STARTER_DATA_W=8 and STARTER_DEPTH=16.
  - A typedef for a beat struct {data, valid} used by agents and scoreboard.
- Natural sub-module starter_fifo_mem: parametrised DATA_W×DEPTH register array, one write port, one asynchronous read port.
- Pointer, level, flag and drop logic live in starter_stream_buffer.

Test Plan:
- Fill/drain: push 0x01..0x10 (16 beats, out_ready=0) → level=16, afull=1 from the 12th beat, overflow=0. Then out_ready=1 → output 0x01..0x10 in order, level back to 0, out_valid=0.
- Overflow: FIFO full, out_ready=0, push 3 more beats → overflow=1, drop_cnt=3, contents unchanged. Drain yields the original 16 beats only.
- Full push+pop: level=16, in_valid=1 (0xAA) with out_ready=1 in the same cycle → no drop, level stays 16, 0xAA emerges 16th after the current head.
- Stall stability: one beat 0x5C, out_ready=0 for 5 cycles → out_valid=1 and out_data=0x5C constant. out_ready=1 → level=0 next cycle.
- Clear race and saturation:
  - DROP_W=2, drop 5 beats → drop_cnt=3.
  - clr_ovf together with a drop → overflow=1, drop_cnt=1.
  - clr_ovf alone → both 0.
- Async reset: rst asserted mid-cycle with level=7 → level=0 and out_valid=0 before the next clk edge. The first push after release appears at rd_ptr 0.
